// File: rtl/echo_meas_pkg.sv
// Shared definitions for the ultrasonic ranging receive path: FSM state codes and default parameters.
package echo_meas_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_RISE = 2'd1;
    localparam logic [1:0] ST_MEASURE   = 2'd2;
    localparam logic [1:0] ST_HOLDOFF   = 2'd3;

    localparam int DEF_DIV        = 50;
    localparam int DEF_WIDTH      = 16;
    localparam int DEF_RISE_LIMIT = 1000;

    // The shared tick counter must hold both the result range and the rise-wait limit.
    function automatic int cnt_bits(input int width, input int limit);
        return (width > $clog2(limit + 1)) ? width : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for an asynchronous input plus a history flop for single-cycle edge strobes.
module echo_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic hist_q, hist_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
        end
    end

    assign level = sync2_q;
    assign rise  = sync2_q & ~hist_q;
    assign fall  = ~sync2_q & hist_q;

endmodule

// File: rtl/echo_meas.sv
// Times the ultrasonic echo pulse in prescaled ticks; reports missing (no rise) or saturated echoes as timeouts.
module echo_meas
    import echo_meas_pkg::*;
#(
    parameter int DIV        = DEF_DIV,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int RISE_LIMIT = DEF_RISE_LIMIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             echo,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] width,
    output logic             timeout
);

    localparam int PW = $clog2(DIV);
    localparam int CW = cnt_bits(WIDTH, RISE_LIMIT);

    logic echo_level, echo_rise, echo_fall;

    echo_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (echo),
        .level (echo_level),
        .rise  (echo_rise),
        .fall  (echo_fall)
    );

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] width_q, width_d;
    logic             timeout_q, timeout_d;
    logic             tick;

    always_comb begin
        tick      = (presc_q == PW'(DIV - 1));
        presc_d   = tick ? '0 : presc_q + PW'(1);
        state_d   = state_q;
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        width_d   = width_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_WAIT_RISE;
                    cnt_d   = '0;
                    presc_d = '0;
                end
            end
            ST_WAIT_RISE: begin
                if (echo_rise) begin
                    state_d = ST_MEASURE;
                    cnt_d   = '0;
                    // The rise-strobe cycle is the first high cycle, so the prescaler starts one step in;
                    // with the fall-cycle tick excluded this yields floor(high_cycles / DIV).
                    presc_d = PW'(1);
                end else if (cnt_q == CW'(RISE_LIMIT)) begin
                    state_d   = ST_IDLE;
                    width_d   = '0;
                    timeout_d = 1'b1;
                    valid_d   = 1'b1;
                    presc_d   = '0;
                end else if (tick) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_MEASURE: begin
                if (echo_fall) begin
                    state_d   = ST_IDLE;
                    width_d   = cnt_q[WIDTH-1:0];
                    timeout_d = 1'b0;
                    valid_d   = 1'b1;
                    presc_d   = '0;
                end else if (tick && (cnt_q[WIDTH-1:0] == '1)) begin
                    state_d   = ST_HOLDOFF;
                    width_d   = '1;
                    timeout_d = 1'b1;
                    valid_d   = 1'b1;
                    presc_d   = '0;
                end else if (tick) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                // Holdoff: a stuck-high echo must drop before the block can re-arm.
                if (!echo_level) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            width_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            width_q   <= width_d;
            timeout_q <= timeout_d;
        end
    end

    assign ready   = ready_q;
    assign valid   = valid_q;
    assign width   = width_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_echo_meas.sv
// Bench for echo_meas: table of nominal/fractional/no-echo cases, hand sequences for corner cases, random widths.
module tb_echo_meas;

    localparam int DIV        = 10;
    localparam int WIDTH      = 8;
    localparam int RISE_LIMIT = 20;
    localparam int MAXW       = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             echo;
    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] width;
    logic             timeout;

    int n_checks = 0;
    int n_fail   = 0;

    int          vcount   = 0;
    logic [31:0] vwidth   = '0;
    logic        vtimeout = 1'b0;

    echo_meas #(
        .DIV        (DIV),
        .WIDTH      (WIDTH),
        .RISE_LIMIT (RISE_LIMIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .echo    (echo),
        .ready   (ready),
        .valid   (valid),
        .width   (width),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            vcount   = vcount + 1;
            vwidth   = 32'(width);
            vtimeout = timeout;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got no end required end");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string name;
        int    rise_delay;
        int    high;
        bit    no_echo;
        int    exp_w;
        bit    exp_to;
    } vec_t;

    // Reference: echo high for H clk cycles measures floor(H/DIV) ticks, saturating with a timeout flag.
    function automatic int model_width(input int high);
        return (high / DIV > MAXW) ? MAXW : high / DIV;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic pulse_enable();
        @(negedge clk) enable = 1'b1;
        @(negedge clk) enable = 1'b0;
    endtask

    task automatic wait_result(input int prev, input int bound, output bit got);
        got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            if (vcount > prev) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_case(input string name, input int rise_delay, input int high, input bit no_echo,
                            input int exp_w, input bit exp_to);
        int prev;
        bit got;
        prev = vcount;
        check({name, "_ready_before"}, 32'(ready), 32'd1);
        pulse_enable();
        check({name, "_ready_busy"}, 32'(ready), 32'd0);
        if (!no_echo) begin
            repeat (rise_delay) @(negedge clk);
            echo = 1'b1;
            repeat (high) @(negedge clk);
            echo = 1'b0;
        end
        wait_result(prev, no_echo ? 400 : 40, got);
        check({name, "_valid_seen"}, 32'(got), 32'd1);
        check({name, "_width"}, vwidth, 32'(exp_w));
        check({name, "_timeout"}, 32'(vtimeout), 32'(exp_to));
        repeat (5) @(negedge clk);
        check({name, "_one_valid"}, 32'(vcount - prev), 32'd1);
        check({name, "_ready_after"}, 32'(ready), 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        int prev;
        int rd;
        int hi;

        vecs.push_back('{"nominal",   30, 100, 1'b0, 10, 1'b0});
        vecs.push_back('{"frac_109",  30, 109, 1'b0, 10, 1'b0});
        vecs.push_back('{"frac_110",  30, 110, 1'b0, 11, 1'b0});
        vecs.push_back('{"short_9",   30,   9, 1'b0,  0, 1'b0});
        vecs.push_back('{"one_cycle",  5,   1, 1'b0,  0, 1'b0});
        vecs.push_back('{"exact_div",  0,  10, 1'b0,  1, 1'b0});
        vecs.push_back('{"no_echo",    0,   0, 1'b1,  0, 1'b1});
        vecs.push_back('{"after_to",  12, 255, 1'b0, 25, 1'b0});

        rst    = 1'b1;
        enable = 1'b0;
        echo   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_width", 32'(width), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        repeat (2) @(negedge clk);

        foreach (vecs[i])
            run_case(vecs[i].name, vecs[i].rise_delay, vecs[i].high, vecs[i].no_echo,
                     vecs[i].exp_w, vecs[i].exp_to);

        // Overlong echo saturates while still high, then holds off until the line drops.
        prev = vcount;
        pulse_enable();
        repeat (5) @(negedge clk);
        echo = 1'b1;
        repeat (3000) @(negedge clk);
        check("sat_valid", 32'(vcount - prev), 32'd1);
        check("sat_width", vwidth, 32'(MAXW));
        check("sat_timeout", 32'(vtimeout), 32'd1);
        check("sat_ready_holdoff", 32'(ready), 32'd0);
        echo = 1'b0;
        repeat (8) @(negedge clk);
        check("sat_ready_after", 32'(ready), 32'd1);
        check("sat_no_second_valid", 32'(vcount - prev), 32'd1);

        // Reset in the middle of a measurement aborts without a result.
        prev = vcount;
        pulse_enable();
        repeat (10) @(negedge clk);
        echo = 1'b1;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        echo = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_mid_no_valid", 32'(vcount - prev), 32'd0);
        check("rst_mid_ready", 32'(ready), 32'd1);
        check("rst_mid_width", 32'(width), 32'd0);
        check("rst_mid_timeout", 32'(timeout), 32'd0);
        run_case("post_reset", 10, 50, 1'b0, 5, 1'b0);

        // Echo already high at accept, plus enable pulses while measuring.
        echo = 1'b1;
        repeat (10) @(negedge clk);
        prev = vcount;
        pulse_enable();
        repeat (50) @(negedge clk);
        check("prehigh_no_result", 32'(vcount - prev), 32'd0);
        check("prehigh_busy", 32'(ready), 32'd0);
        echo = 1'b0;
        repeat (10) @(negedge clk);
        echo = 1'b1;
        repeat (20) @(negedge clk);
        pulse_enable();
        repeat (20) @(negedge clk);
        pulse_enable();
        repeat (16) @(negedge clk);
        echo = 1'b0;
        repeat (30) @(negedge clk);
        check("prehigh_one_valid", 32'(vcount - prev), 32'd1);
        check("prehigh_width", vwidth, 32'd6);
        check("prehigh_timeout", 32'(vtimeout), 32'd0);
        check("prehigh_ready", 32'(ready), 32'd1);

        for (int k = 0; k < 16; k++) begin
            rd = int'($urandom_range(0, 150));
            hi = int'($urandom_range(1, 600));
            run_case($sformatf("rand%0d", k), rd, hi, 1'b0, model_width(hi), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
